// File: rtl/ram_dump_pkg.sv
// Shared definitions for the RAM dump streamer: FSM states and default widths.
package ram_dump_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_dump.sv
// RAM dump streamer: reads an inclusive, possibly wrapping address range from a
// synchronous single-port RAM and offers each word on a valid/ready stream.
module ram_dump
  import ram_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_out,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              ram_cen_q, ram_cen_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, datapath and output decode; outputs are registered from state_d
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    tx_data_d  = tx_data_q;
    ram_addr_d = ram_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          state_d    = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        tx_data_d = ram_out;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (cur_addr_q == end_addr_q) begin
            state_d = FIN;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = READ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides any progress, including a transfer in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    ram_cen_d  = (state_d == READ);
    if (ram_cen_d) begin
      ram_addr_d = cur_addr_d;
    end
    tx_valid_d = (state_d == SEND);
    tx_last_d  = tx_valid_d && (cur_addr_d == end_addr_d);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      ram_addr_q <= '0;
      tx_data_q  <= '0;
      ram_cen_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      ram_addr_q <= ram_addr_d;
      tx_data_q  <= tx_data_d;
      ram_cen_q  <= ram_cen_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_cen  = ram_cen_q;
  assign ram_wen  = 1'b0;
  assign ram_addr = ram_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/ram_dump.md
RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width in bits.
REQ-002 Parameter DATA_W, default 16, RAM and stream word width in bits.
REQ-003 clk  input  1  sole clock; every state change occurs on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 first_addr  input  ADDR_W  first RAM address to dump; sampled with start.
REQ-007 last_addr  input  ADDR_W  last RAM address to dump, inclusive; sampled with start.
REQ-008 abort  input  1  terminates a dump in progress.
REQ-009 ram_cen  output  1  RAM chip enable, high for exactly one cycle per read.
REQ-010 ram_wen  output  1  RAM write enable, held 0 at all times (read-only master).
REQ-011 ram_addr  output  ADDR_W  RAM read address.
REQ-012 ram_out  input  DATA_W  RAM read data, valid the cycle after ram_cen high.
REQ-013 tx_valid  output  1  stream word available.
REQ-014 tx_ready  input  1  stream sink accepts word; transfer occurs when tx_valid and tx_ready are both high.
REQ-015 tx_data  output  DATA_W  stream word.
REQ-016 tx_last  output  1  high with the word read from last_addr.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on normal completion.

Function
REQ-019 FSM states: IDLE, READ, CAPT, SEND, FIN.
- IDLE: start=1 loads cur_addr=first_addr and end_addr=last_addr, then goes to READ.
- READ: drives ram_cen=1 and ram_addr=cur_addr, then goes to CAPT.
- CAPT: registers ram_out into tx_data, then goes to SEND.
- SEND: drives tx_valid=1.
  - On transfer with cur_addr==end_addr: goes to FIN.
  - On transfer otherwise: sets cur_addr=cur_addr+1, then goes to READ.
- FIN: drives done=1 for one cycle, then goes to IDLE.
REQ-020 With tx_ready held high, the block transfers one word every 3 cycles; the first tx_valid occurs 3 cycles after the start cycle.
REQ-021 tx_data and tx_last remain stable while tx_valid=1 and tx_ready=0.
REQ-022 tx_last = (cur_addr==end_addr) whenever in SEND; 0 otherwise.
REQ-023 cur_addr increments modulo 2^ADDR_W.
- If last_addr < first_addr, the dump wraps through all-ones to 0.
- Word count = ((last_addr-first_addr) mod 2^ADDR_W)+1.
REQ-024 first_addr==last_addr dumps exactly one word, with tx_last=1.
REQ-025 first_addr=0 with last_addr=all-ones dumps 2^ADDR_W words and terminates without wrapping again.
REQ-026 start while busy=1 is ignored; the latched range is unaffected.
REQ-027 abort=1 in any non-IDLE state goes to IDLE on the next edge.
- tx_valid, ram_cen and done are 0 from that edge on.
- A word offered in SEND is withdrawn even if unaccepted.
- done is not pulsed.
REQ-028 abort has priority over start and over a simultaneous SEND transfer; a word accepted in the abort cycle counts as delivered.
REQ-029 tx_ready is ignored outside SEND.

Reset
REQ-030 reset=1 forces IDLE on the next rising clk regardless of state or other inputs, including mid-dump.
REQ-031 Reset values:
- tx_valid=0, tx_last=0, done=0, busy=0, ram_cen=0, ram_wen=0.
- tx_data=0, ram_addr=0, internal cur_addr=0, end_addr=0.
REQ-032 reset has priority over abort and start.

Structure
REQ-033 The shared core package holds:
- the FSM state enumeration (IDLE, READ, CAPT, SEND, FIN);
- default ADDR_W and DATA_W constants.
REQ-034 Single flat module; no sub-module required. The address counter stays inline.

Verification
REQ-035 RAM preloaded with mem[a]=a^16'hA5A5; first=0x0010, last=0x0013, tx_ready=1:
- 4 words A5B5, A5B4, A5B7, A5B6 in that order;
- tx_last only on A5B6;
- done 1 cycle after the last transfer;
- first tx_valid 3 cycles after start.
REQ-036 first=0xFFFE, last=0x0001: words from addresses FFFE, FFFF, 0000, 0001 (5A5B, 5A5A, A5A5, A5A4); tx_last on the 4th.
REQ-037 first=last=0x0100, tx_ready low for 5 cycles then high:
- tx_data=A4A5 held stable throughout the stall;
- exactly one transfer, with tx_last=1;
- done pulses once.
REQ-038 Random tx_ready backpressure over 64 words:
- stream equals RAM contents in order;
- ram_wen never 1;
- ram_cen pulses exactly 64 times.
REQ-039 abort asserted in SEND mid-dump:
- tx_valid=0 and busy=0 the next cycle; done never pulses;
- a following start dumps correctly.
REQ-040 reset asserted in CAPT, and start pulsed while busy:
- reset gives IDLE with all REQ-031 values;
- the start-while-busy changes neither the word count nor the addresses.
